// File: rtl/bram_dma_multi.sv
// Descriptor-driven banked BRAM to BRAM copy engine with abort and error pulse.
// Define BRAM_DMA_PERF_EN to add cycle and word performance counters.
module bram_dma_multi #(
  parameter int SRC_BANKS  = 16,
  parameter int SRC_DEPTH  = 1024,
  parameter int DST_ADDR_W = 18,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LAT     = 1,
  localparam int BW = $clog2(SRC_BANKS),
  localparam int AW = $clog2(SRC_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [AW-1:0]         cfg_src_base_i,
  input  logic [AW:0]           cfg_burst_i,
  input  logic [BW:0]           cfg_blocks_i,
  input  logic [DST_ADDR_W-1:0] cfg_dst_base_i,
  input  logic [DST_ADDR_W-1:0] cfg_dst_stride_i,
  input  logic                  abort_i,
  output logic                  src_en_o,
  output logic [BW+AW-1:0]      src_addr_o,
  input  logic [DATA_WIDTH-1:0] src_rdata_i,
  output logic                  dst_we_o,
  output logic [DST_ADDR_W-1:0] dst_addr_o,
  output logic [DATA_WIDTH-1:0] dst_wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
`ifdef BRAM_DMA_PERF_EN
  ,
  output logic [31:0]           perf_cycles_o,
  output logic [AW+BW:0]        perf_words_o
`endif
);

  localparam logic [BW:0]   BANKS_C = (BW+1)'(SRC_BANKS);
  localparam logic [AW+1:0] DEPTH_C = (AW+2)'(SRC_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nx;

  logic [AW-1:0]         base_q;
  logic [AW:0]           burst_q;
  logic [BW:0]           blocks_q;
  logic [DST_ADDR_W-1:0] stride_q;
  logic [DST_ADDR_W-1:0] row_q;
  logic [BW-1:0]         bank_q;
  logic [AW-1:0]         off_q;
  logic                  err_q;

  logic [RD_LAT-1:0]     vld_q;
  logic [RD_LAT-1:0]     vld_lo;
  logic [DST_ADDR_W-1:0] adr_q [RD_LAT];

  logic [AW+1:0]         span;
  logic [DST_ADDR_W-1:0] cur_dst;
  logic cfg_bad, accept, rd;
  logic off_end, bank_end, last_rd, drain_ok;

  assign span    = {2'b00, cfg_src_base_i} + {1'b0, cfg_burst_i};
  assign cfg_bad = (cfg_burst_i == '0) || (cfg_blocks_i == '0) ||
                   (cfg_blocks_i > BANKS_C) || (span > DEPTH_C);
  assign accept  = (state == IDLE) && start_i && !cfg_bad;
  assign rd      = (state == RUN) && !abort_i;

  assign off_end  = ({1'b0, off_q} == burst_q - 1'b1);
  assign bank_end = ({1'b0, bank_q} == blocks_q - 1'b1);
  assign last_rd  = rd && off_end && bank_end;

  // The last stage drains in the same cycle DONE is entered.
  assign vld_lo   = vld_q << 1;
  assign drain_ok = (vld_lo == '0);

  assign cur_dst = row_q + DST_ADDR_W'(off_q);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (abort_i || last_rd) state_nx = DRAIN;
      DRAIN:   if (drain_ok) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    src_en_o   = rd;
    src_addr_o = '0;
    busy_o     = (state == RUN) || (state == DRAIN);
    done_o     = (state == DONE);
    if (rd) src_addr_o = {bank_q, base_q + off_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q   <= '0;
      burst_q  <= '0;
      blocks_q <= '0;
      stride_q <= '0;
      row_q    <= '0;
      bank_q   <= '0;
      off_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && start_i && cfg_bad;
      if ((state == IDLE) && start_i) begin
        base_q   <= cfg_src_base_i;
        burst_q  <= cfg_burst_i;
        blocks_q <= cfg_blocks_i;
        stride_q <= cfg_dst_stride_i;
        row_q    <= cfg_dst_base_i;
        bank_q   <= '0;
        off_q    <= '0;
      end else if (rd) begin
        if (off_end) begin
          off_q  <= '0;
          bank_q <= bank_q + 1'b1;
          row_q  <= row_q + stride_q;
        end else begin
          off_q <= off_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) adr_q[i] <= '0;
    end else begin
      vld_q[0] <= rd;
      adr_q[0] <= cur_dst;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        adr_q[i] <= adr_q[i-1];
      end
    end
  end

  assign dst_we_o    = vld_q[RD_LAT-1];
  assign dst_addr_o  = dst_we_o ? adr_q[RD_LAT-1] : '0;
  assign dst_wdata_o = src_rdata_i;
  assign err_o       = err_q;

`ifdef BRAM_DMA_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cycles_o <= '0;
      perf_words_o  <= '0;
    end else if (accept) begin
      perf_cycles_o <= '0;
      perf_words_o  <= '0;
    end else begin
      if (busy_o)   perf_cycles_o <= perf_cycles_o + 1'b1;
      if (dst_we_o) perf_words_o  <= perf_words_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_dma_multi.sv
// Bench for bram_dma_multi: three instances (RD_LAT 1..3) share one descriptor
// stream and are compared against an address/data model built from the copy rules.
module tb_bram_dma_multi;

  localparam int NI = 3;
  localparam int AW = 10;
  localparam int BW = 4;
  localparam int DW = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start, abort;
  logic [AW-1:0] c_base;
  logic [AW:0]   c_burst;
  logic [BW:0]   c_blocks;
  logic [DW-1:0] c_dst, c_stride;

  logic          src_en    [NI];
  logic [13:0]   src_addr  [NI];
  logic [7:0]    src_rdata [NI];
  logic          dst_we    [NI];
  logic [DW-1:0] dst_addr  [NI];
  logic [7:0]    dst_wdata [NI];
  logic          busy      [NI];
  logic          done      [NI];
  logic          err       [NI];
  logic [7:0]    rpipe     [NI][4];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    bram_dma_multi #(.RD_LAT(g + 1)) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start_i          (start),
      .cfg_src_base_i   (c_base),
      .cfg_burst_i      (c_burst),
      .cfg_blocks_i     (c_blocks),
      .cfg_dst_base_i   (c_dst),
      .cfg_dst_stride_i (c_stride),
      .abort_i          (abort),
      .src_en_o         (src_en[g]),
      .src_addr_o       (src_addr[g]),
      .src_rdata_i      (src_rdata[g]),
      .dst_we_o         (dst_we[g]),
      .dst_addr_o       (dst_addr[g]),
      .dst_wdata_o      (dst_wdata[g]),
      .busy_o           (busy[g]),
      .done_o           (done[g]),
      .err_o            (err[g])
    );
    assign src_rdata[g] = rpipe[g][g];
  end

  function automatic logic [7:0] word(input int b, input int o);
    return 8'((b * 29 + o * 7 + (o >> 4)) & 255);
  endfunction

  // Source banks: word of the read address appears RD_LAT cycles later.
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      rpipe[g][0] <= src_en[g] ?
        word(int'(src_addr[g][13:10]), int'(src_addr[g][9:0])) : 8'h00;
      for (int i = 1; i < 4; i++) rpipe[g][i] <= rpipe[g][i-1];
    end
  end

  typedef struct {
    int base;
    int burst;
    int blocks;
    int dst;
    int stride;
    int abort_k;
    bit exp_err;
    int exp_n;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit desc_bad(input vec_t v);
    return v.burst == 0 || v.blocks == 0 || v.blocks > 16 ||
           v.base + v.burst > 1024;
  endfunction

  function automatic logic [13:0] exp_src(input vec_t v, input int j);
    int b, o;
    b = (v.burst > 0) ? j / v.burst : 0;
    o = (v.burst > 0) ? j % v.burst : 0;
    return {4'(b), 10'(v.base + o)};
  endfunction

  function automatic logic [DW-1:0] exp_dst(input vec_t v, input int j);
    int b, o;
    b = (v.burst > 0) ? j / v.burst : 0;
    o = (v.burst > 0) ? j % v.burst : 0;
    return DW'(v.dst + b * v.stride + o);
  endfunction

  function automatic logic [7:0] exp_dat(input vec_t v, input int j);
    int b, o;
    b = (v.burst > 0) ? j / v.burst : 0;
    o = (v.burst > 0) ? j % v.burst : 0;
    return word(b, v.base + o);
  endfunction

  task automatic run_xfer(input vec_t v, input string tag);
    int nr, limit, ed, lw;
    int reads [NI];
    int writes[NI];
    int bad_rd[NI];
    int bad_wr[NI];
    int busy_n[NI];
    int done_n[NI];
    int done_at[NI];
    int err_n [NI];
    int err_at[NI];
    nr = v.exp_err ? 0 : v.exp_n;
    for (int g = 0; g < NI; g++) begin
      reads[g] = 0; writes[g] = 0; bad_rd[g] = 0; bad_wr[g] = 0;
      busy_n[g] = 0; done_n[g] = 0; done_at[g] = 0;
      err_n[g] = 0; err_at[g] = 0;
    end
    @(negedge clk);
    c_base   = v.base[AW-1:0];
    c_burst  = v.burst[AW:0];
    c_blocks = v.blocks[BW:0];
    c_dst    = v.dst[DW-1:0];
    c_stride = v.stride[DW-1:0];
    start    = 1'b1;
    limit    = nr + 12;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      start = (v.abort_k >= 5) && (i == 3 || i == 5);
      abort = (v.abort_k >= 0) && (i == v.abort_k + 1);
      #1;
      for (int g = 0; g < NI; g++) begin
        if (src_en[g]) begin
          if (src_addr[g] !== exp_src(v, reads[g]) || i != reads[g] + 1)
            bad_rd[g]++;
          reads[g]++;
        end
        if (dst_we[g]) begin
          if (dst_addr[g] !== exp_dst(v, writes[g]) ||
              dst_wdata[g] !== exp_dat(v, writes[g]) ||
              i != writes[g] + 2 + g)
            bad_wr[g]++;
          writes[g]++;
        end
        if (busy[g]) busy_n[g]++;
        if (done[g]) begin done_n[g]++; done_at[g] = i; end
        if (err[g])  begin err_n[g]++;  err_at[g] = i;  end
      end
    end
    start = 1'b0;
    abort = 1'b0;
    for (int g = 0; g < NI; g++) begin
      check($sformatf("%s L%0d reads", tag, g + 1), reads[g], nr);
      check($sformatf("%s L%0d read_addr", tag, g + 1), bad_rd[g], 0);
      check($sformatf("%s L%0d writes", tag, g + 1), writes[g], nr);
      check($sformatf("%s L%0d write_addr_data", tag, g + 1), bad_wr[g], 0);
      check($sformatf("%s L%0d err_pulses", tag, g + 1), err_n[g], v.exp_err);
      if (v.exp_err) begin
        check($sformatf("%s L%0d err_cycle", tag, g + 1), err_at[g], 1);
        check($sformatf("%s L%0d busy_cycles", tag, g + 1), busy_n[g], 0);
        check($sformatf("%s L%0d done_pulses", tag, g + 1), done_n[g], 0);
      end else begin
        if (v.abort_k >= 0) begin
          lw = (nr > 0) ? nr + g + 1 : 0;
          ed = ((lw > nr + 2) ? lw : nr + 2) + 1;
        end else begin
          ed = nr + g + 2;
        end
        check($sformatf("%s L%0d done_pulses", tag, g + 1), done_n[g], 1);
        check($sformatf("%s L%0d done_cycle", tag, g + 1), done_at[g], ed);
        check($sformatf("%s L%0d busy_cycles", tag, g + 1), busy_n[g], ed - 1);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int g = 0; g < NI; g++)
      check($sformatf("%s L%0d outputs", tag, g + 1),
            longint'({src_en[g], src_addr[g], dst_we[g], dst_addr[g],
                      busy[g], done[g], err[g]}), 0);
  endtask

  vec_t tbl[9];
  vec_t rv;
  int   act;

  initial begin
    start = 1'b0; abort = 1'b0;
    c_base = '0; c_burst = '0; c_blocks = '0; c_dst = '0; c_stride = '0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    tbl[0] = '{0,    196, 6,  0,         196,    -1, 1'b0, 1176};
    tbl[1] = '{196,  100, 16, 'h10000,   100,    -1, 1'b0, 1600};
    tbl[2] = '{0,    4,   2,  'h3FFFC,   8,      -1, 1'b0, 8};
    tbl[3] = '{0,    0,   4,  0,         1,      -1, 1'b1, 0};
    tbl[4] = '{0,    4,   17, 0,         1,      -1, 1'b1, 0};
    tbl[5] = '{1000, 30,  1,  0,         1,      -1, 1'b1, 0};
    tbl[6] = '{5,    7,   3,  100,       50,     10, 1'b0, 10};
    tbl[7] = '{3,    5,   2,  9,         16,     0,  1'b0, 0};
    tbl[8] = '{1000, 24,  16, 'h3F000,   'h1234, -1, 1'b0, 384};
    for (int t = 0; t < 9; t++) run_xfer(tbl[t], $sformatf("vec%0d", t));

    for (int r = 0; r < 6; r++) begin
      rv.base    = int'($urandom_range(0, 1023));
      rv.burst   = int'($urandom_range(1, 40));
      rv.blocks  = int'($urandom_range(1, 17));
      rv.dst     = int'($urandom_range(0, 262143));
      rv.stride  = int'($urandom_range(0, 262143));
      if (r == 0) rv.base = 1024 - rv.burst;
      rv.exp_err = desc_bad(rv);
      rv.exp_n   = rv.burst * rv.blocks;
      rv.abort_k = -1;
      if (!rv.exp_err && rv.exp_n > 12 && $urandom_range(0, 2) == 0) begin
        rv.abort_k = int'($urandom_range(5, rv.exp_n - 1));
        rv.exp_n   = rv.abort_k;
      end
      run_xfer(rv, $sformatf("rnd%0d", r));
    end

    @(negedge clk);
    c_base = 10'd7; c_burst = 11'd50; c_blocks = 5'd4;
    c_dst = 18'd300; c_stride = 18'd64;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_idle_outputs("midreset");
    act = 0;
    repeat (8) begin
      @(negedge clk);
      #1;
      for (int g = 0; g < NI; g++)
        if (src_en[g] || dst_we[g] || busy[g] || done[g] || err[g]) act++;
    end
    check("midreset trailing_activity", act, 0);
    rv = '{11, 9, 5, 1000, 77, -1, 1'b0, 45};
    run_xfer(rv, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
